print_arbiter: RTL and testbench

PRINT_ARBITER -- requirements
Module: print_arbiter

---
 rtl/print_arbiter.sv | 158 +++++++++++++++
 tb/tb_print_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/print_arbiter.sv
// Two-requester print-word arbiter: round-robin into a 4-deep FIFO, then drains
// the buffered words as write bursts on a shared bus.
module print_arbiter #(
  parameter logic [31:0] baseAddr = 32'h50000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_data_i,
  output logic        req1_ready_o,
  output logic        bus_request_o,
  input  logic        bus_grant_i,
  output logic [31:0] bus_addrData_o,
  output logic [3:0]  bus_byteEnables_o,
  output logic [7:0]  bus_burstSize_o,
  output logic        bus_readNWrite_o,
  output logic        bus_beginTransaction_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  input  logic        bus_busy_i,
  input  logic        bus_error_i,
  output logic [2:0]  fifoCount_o
);
  localparam int fifoDepth = 4;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEGIN, S_DATA, S_END} state_t;

  state_t      r_state;
  logic [31:0] r_mem [fifoDepth];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count, r_burst_len, r_beat;
  logic        r_last;
  logic        r_request, r_begin, r_end, r_dv;
  logic [31:0] r_addr_data;
  logic [3:0]  r_byte_en;
  logic [7:0]  r_burst_size;

  logic        w_can_push, w_pick1, w_push, w_pop, w_last_beat;
  logic [31:0] w_push_data, w_head, w_head_next;

  // r_last = 1 means requester 1 was accepted most recently, so requester 0 wins a tie
  assign w_can_push   = !rst_i && (r_count < 3'(fifoDepth));
  assign w_pick1      = req1_valid_i && (!req0_valid_i || !r_last);
  assign req0_ready_o = w_can_push && req0_valid_i && !w_pick1;
  assign req1_ready_o = w_can_push && w_pick1;
  assign w_push       = req0_ready_o || req1_ready_o;
  assign w_push_data  = w_pick1 ? req1_data_i : req0_data_i;
  assign w_pop        = (r_state == S_DATA) && !bus_busy_i && !bus_error_i;
  assign w_last_beat  = (r_beat == r_burst_len - 3'd1);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_next  = r_mem[r_rd_ptr + 2'd1];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
        r_last   <= w_pick1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bus outputs are registered and default to zero so the bus can be OR-combined.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_burst_len  <= '0;
      r_beat       <= '0;
      r_request    <= 1'b0;
      r_begin      <= 1'b0;
      r_end        <= 1'b0;
      r_dv         <= 1'b0;
      r_addr_data  <= '0;
      r_byte_en    <= '0;
      r_burst_size <= '0;
    end else begin
      r_request    <= 1'b0;
      r_begin      <= 1'b0;
      r_end        <= 1'b0;
      r_dv         <= 1'b0;
      r_addr_data  <= '0;
      r_byte_en    <= '0;
      r_burst_size <= '0;
      case (r_state)
        S_IDLE: begin
          // An incoming push already counts, giving push-to-begin in two cycles
          if (r_count != 3'd0 || w_push) begin
            r_state   <= S_REQ;
            r_request <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_grant_i) begin
            r_state      <= S_BEGIN;
            r_burst_len  <= r_count;
            r_begin      <= 1'b1;
            r_addr_data  <= baseAddr;
            r_byte_en    <= 4'hF;
            r_burst_size <= {5'd0, r_count - 3'd1};
          end else begin
            r_request <= 1'b1;
          end
        end
        S_BEGIN: begin
          if (bus_error_i) begin
            r_state <= S_END;
            r_end   <= 1'b1;
          end else begin
            r_state     <= S_DATA;
            r_beat      <= '0;
            r_dv        <= 1'b1;
            r_addr_data <= w_head;
            r_byte_en   <= 4'hF;
          end
        end
        S_DATA: begin
          if (bus_error_i || (!bus_busy_i && w_last_beat)) begin
            r_state <= S_END;
            r_end   <= 1'b1;
          end else begin
            r_dv        <= 1'b1;
            r_byte_en   <= 4'hF;
            r_addr_data <= bus_busy_i ? w_head : w_head_next;
            if (!bus_busy_i) r_beat <= r_beat + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_request_o          = r_request;
  assign bus_beginTransaction_o = r_begin;
  assign bus_endTransaction_o   = r_end;
  assign bus_dataValid_o        = r_dv;
  assign bus_addrData_o         = r_addr_data;
  assign bus_byteEnables_o      = r_byte_en;
  assign bus_burstSize_o        = r_burst_size;
  assign bus_readNWrite_o       = 1'b0;
  assign fifoCount_o            = r_count;
endmodule

// File: tb/tb_print_arbiter.sv
// Directed scenarios plus a random phase, checked each cycle against a queue-based
// model of the buffer, round-robin rule and bus framing.
module tb_print_arbiter;
  localparam logic [31:0] BASE = 32'h50000000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [31:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o;
  logic        bus_request_o, bus_grant_i;
  logic [31:0] bus_addrData_o;
  logic [3:0]  bus_byteEnables_o;
  logic [7:0]  bus_burstSize_o;
  logic        bus_readNWrite_o, bus_beginTransaction_o, bus_endTransaction_o, bus_dataValid_o;
  logic        bus_busy_i, bus_error_i;
  logic [2:0]  fifoCount_o;

  print_arbiter #(.baseAddr(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .bus_request_o(bus_request_o), .bus_grant_i(bus_grant_i),
    .bus_addrData_o(bus_addrData_o), .bus_byteEnables_o(bus_byteEnables_o),
    .bus_burstSize_o(bus_burstSize_o), .bus_readNWrite_o(bus_readNWrite_o),
    .bus_beginTransaction_o(bus_beginTransaction_o), .bus_endTransaction_o(bus_endTransaction_o),
    .bus_dataValid_o(bus_dataValid_o), .bus_busy_i(bus_busy_i), .bus_error_i(bus_error_i),
    .fifoCount_o(fifoCount_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  bit started = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit m_last = 1;
  bit exp_req = 0, exp_begin = 0, exp_end = 0, in_data = 0;
  int exp_burst = 0, beats_left = 0;

  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (started) begin
      if (rst_i) begin
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);
        mq.delete();
        m_last = 1; exp_req = 0; exp_begin = 0; exp_end = 0; in_data = 0;
        exp_burst = 0; beats_left = 0;
      end else begin
        bit can, e_r0, e_r1, idle, nr, nb, ne, nd;
        int win;
        can  = mq.size() < 4;
        win  = (req0_valid_i && req1_valid_i) ? (m_last ? 0 : 1) : (req0_valid_i ? 0 : 1);
        e_r0 = can && req0_valid_i && (win == 0);
        e_r1 = can && req1_valid_i && (win == 1);
        chk("fifo_count", fifoCount_o, mq.size());
        chk("ready0", req0_ready_o, e_r0);
        chk("ready1", req1_ready_o, e_r1);
        chk("read_n_write", bus_readNWrite_o, 0);
        chk("request", bus_request_o, exp_req);
        chk("begin", bus_beginTransaction_o, exp_begin);
        chk("end", bus_endTransaction_o, exp_end);
        chk("data_valid", bus_dataValid_o, in_data);
        if (exp_begin) begin
          chk("begin_addr", bus_addrData_o, BASE);
          chk("begin_burst_size", bus_burstSize_o, exp_burst - 1);
          chk("begin_byte_en", bus_byteEnables_o, 4'hF);
        end else begin
          chk("idle_burst_size", bus_burstSize_o, 0);
        end
        if (in_data) chk("beat_byte_en", bus_byteEnables_o, 4'hF);
        if (!exp_begin && !in_data) begin
          chk("idle_addr", bus_addrData_o, 0);
          chk("idle_byte_en", bus_byteEnables_o, 0);
        end

        idle = !exp_req && !exp_begin && !in_data && !exp_end;
        nr = (exp_req && !bus_grant_i) || (idle && (mq.size() > 0 || e_r0 || e_r1));
        nb = exp_req && bus_grant_i;
        if (nb) exp_burst = mq.size();
        ne = 0;
        nd = in_data;
        if (exp_begin) begin
          if (bus_error_i) ne = 1;
          else begin nd = 1; beats_left = exp_burst; end
        end
        if (in_data) begin
          if (mq.size() == 0) chk("beat_queue_size", mq.size(), 1);
          else chk("beat_data", bus_addrData_o, mq[0]);
          if (bus_error_i) begin
            ne = 1; nd = 0;
          end else if (!bus_busy_i) begin
            if (mq.size() > 0) void'(mq.pop_front());
            beats_left--;
            if (beats_left == 0) begin ne = 1; nd = 0; end
          end
        end
        if (e_r0) begin mq.push_back(req0_data_i); m_last = 0; end
        else if (e_r1) begin mq.push_back(req1_data_i); m_last = 1; end
        exp_req = nr; exp_begin = nb; exp_end = ne; in_data = nd;
      end
    end
  end

  task automatic do_reset();
    rst_i = 1; req0_valid_i = 0; req1_valid_i = 0;
    bus_grant_i = 0; bus_busy_i = 0; bus_error_i = 0;
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic push_seq(input int n, input logic [31:0] base);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 40) begin
      req0_valid_i = 1; req0_data_i = base + i;
      @(negedge clk_i);
      if (req0_ready_o) i++;
      tick(); guard++;
    end
    req0_valid_i = 0;
    chk("push_seq_done", i, n);
  endtask

  // Grants the bus, plays the slave side (optional stall/error on a 1-based beat)
  // and records every data-valid cycle into got.
  task automatic run_burst(input int stall_beat, input int stall_n, input int err_beat, output int bsz);
    int accepted = 0;
    int stall_left = stall_n;
    int guard = 0;
    bit done = 0, drop0 = 0;
    got.delete();
    bsz = -1;
    bus_grant_i = 1;
    while (!done && guard < 60) begin
      tick(); guard++;
      if (drop0) req0_valid_i = 0;
      bus_busy_i = 0; bus_error_i = 0;
      if (bus_beginTransaction_o) begin bus_grant_i = 0; bsz = int'(bus_burstSize_o); end
      if (bus_dataValid_o) begin
        if (accepted + 1 == err_beat) bus_error_i = 1;
        else if (accepted + 1 == stall_beat && stall_left > 0) begin bus_busy_i = 1; stall_left--; end
        got.push_back(bus_addrData_o);
        if (!bus_busy_i && !bus_error_i) accepted++;
      end
      if (bus_endTransaction_o) done = 1;
      @(negedge clk_i);
      if (req0_ready_o) drop0 = 1;
    end
    tick();
    bus_grant_i = 0; bus_busy_i = 0; bus_error_i = 0;
    chk("burst_finished", done, 1);
  endtask

  initial begin
    int bsz, i0, i1;
    logic [31:0] a_w[2], b_w[2];
    logic [31:0] exp_order[4];
    rst_i = 1; req0_valid_i = 0; req1_valid_i = 0; req0_data_i = 0; req1_data_i = 0;
    bus_grant_i = 0; bus_busy_i = 0; bus_error_i = 0;
    @(posedge clk_i); started = 1; #1;
    tick(); rst_i = 0;
    @(negedge clk_i);
    chk("reset_count", fifoCount_o, 0);
    chk("reset_request", bus_request_o, 0);
    tick();

    // Single word, immediate grant: push N, request N+1, begin N+2
    bus_grant_i = 1; req0_valid_i = 1; req0_data_i = 32'hDEADBEEF;
    @(negedge clk_i); chk("s1_ready0", req0_ready_o, 1);
    tick(); req0_valid_i = 0;
    @(negedge clk_i); chk("s1_request", bus_request_o, 1);
    tick(); @(negedge clk_i);
    chk("s1_begin", bus_beginTransaction_o, 1);
    chk("s1_addr", bus_addrData_o, BASE);
    chk("s1_bsz", bus_burstSize_o, 0);
    tick(); @(negedge clk_i);
    chk("s1_dv", bus_dataValid_o, 1);
    chk("s1_data", bus_addrData_o, 32'hDEADBEEF);
    tick(); @(negedge clk_i); chk("s1_end", bus_endTransaction_o, 1);
    tick(); @(negedge clk_i); chk("s1_count", fifoCount_o, 0);
    bus_grant_i = 0;
    tick();

    // Contention with grant held off
    do_reset();
    a_w[0] = 32'hA0A0_0000; a_w[1] = 32'hA1A1_0001;
    b_w[0] = 32'hB0B0_0000; b_w[1] = 32'hB1B1_0001;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 4; c++) begin
      req0_valid_i = (i0 < 2); req0_data_i = a_w[i0 < 2 ? i0 : 1];
      req1_valid_i = (i1 < 2); req1_data_i = b_w[i1 < 2 ? i1 : 1];
      @(negedge clk_i);
      if (req0_ready_o) i0++;
      if (req1_ready_o) i1++;
      tick();
    end
    req0_valid_i = 0; req1_valid_i = 0;
    chk("s2_count", fifoCount_o, 4);
    run_burst(0, 0, 0, bsz);
    chk("s2_bsz", bsz, 3);
    chk("s2_beats", got.size(), 4);
    exp_order[0] = a_w[0]; exp_order[1] = b_w[0]; exp_order[2] = a_w[1]; exp_order[3] = b_w[1];
    for (int k = 0; k < 4; k++) chk($sformatf("s2_order%0d", k), got[k], exp_order[k]);

    // Full buffer: fifth word waits for the first pop
    do_reset();
    i0 = 0;
    for (int c = 0; c < 8; c++) begin
      req0_valid_i = 1; req0_data_i = 32'h3000_0000 + i0;
      @(negedge clk_i);
      if (req0_ready_o) i0++;
      tick();
    end
    chk("s3_accepted", i0, 4);
    @(negedge clk_i);
    chk("s3_ready_full", req0_ready_o, 0);
    chk("s3_count", fifoCount_o, 4);
    tick();
    run_burst(0, 0, 0, bsz);
    chk("s3_bsz", bsz, 3);
    run_burst(0, 0, 0, bsz);
    chk("s3_fifth_bsz", bsz, 0);
    chk("s3_fifth_data", got[0], 32'h3000_0004);

    // Stall on beat 2 of 3
    do_reset();
    push_seq(3, 32'h4000_0000);
    run_burst(2, 2, 0, bsz);
    chk("s4_bsz", bsz, 2);
    chk("s4_dv_cycles", got.size(), 5);
    for (int k = 1; k < 4; k++) chk($sformatf("s4_hold%0d", k), got[k], 32'h4000_0001);
    chk("s4_beat3", got[4], 32'h4000_0002);
    @(negedge clk_i); chk("s4_count", fifoCount_o, 0);
    tick();

    // Error on beat 2 of 3, then resend
    do_reset();
    push_seq(3, 32'h5000_1000);
    run_burst(0, 0, 2, bsz);
    chk("s5_bsz", bsz, 2);
    @(negedge clk_i); chk("s5_count_after_err", fifoCount_o, 2);
    tick();
    run_burst(0, 0, 0, bsz);
    chk("s5_resend_bsz", bsz, 1);
    chk("s5_resend_n", got.size(), 2);
    chk("s5_resend0", got[0], 32'h5000_1001);
    chk("s5_resend1", got[1], 32'h5000_1002);

    // Reset in the middle of a data phase
    do_reset();
    push_seq(3, 32'h6000_0000);
    bus_grant_i = 1;
    for (int g = 0; g < 20 && !bus_dataValid_o; g++) tick();
    chk("s6_in_data", bus_dataValid_o, 1);
    bus_grant_i = 0; rst_i = 1;
    tick(); rst_i = 0;
    @(negedge clk_i);
    chk("s6_dv", bus_dataValid_o, 0);
    chk("s6_end", bus_endTransaction_o, 0);
    chk("s6_addr", bus_addrData_o, 0);
    chk("s6_count", fifoCount_o, 0);
    tick();
    push_seq(1, 32'h6666_0000);
    run_burst(0, 0, 0, bsz);
    chk("s6_restart_bsz", bsz, 0);
    chk("s6_restart_data", got[0], 32'h6666_0000);

    // Random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      rst_i = (c % 500 == 499);
      req0_valid_i = ($urandom_range(0, 2) != 0); req0_data_i = $urandom;
      req1_valid_i = ($urandom_range(0, 2) != 0); req1_data_i = $urandom;
      bus_grant_i  = ($urandom_range(0, 3) != 0);
      bus_busy_i   = ($urandom_range(0, 3) == 0);
      bus_error_i  = ($urandom_range(0, 19) == 0);
      tick();
    end
    do_reset();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
